load_port_arbiter: RTL and testbench

- Registered, starvation-safe arbiter for the single load-pipeline issue port, shared by the AGU load path and the page-table walker.
- Default priority goes to AGU loads. A saturating starvation counter forces a page-walker grant after STARVE_LIMIT consecutive losses.
- A one-entry output register decouples requester stalls from the downstream stall. Flush handling drops speculative AGU loads.

---
 rtl/load_port_arbiter.sv | 117 +++++++++++
 tb/tb_load_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_port_arbiter.sv
// Registered arbiter for the shared load-pipeline issue port: AGU loads win by
// default, a saturating loss counter forces a page-walker grant to avoid starvation.
package LoadPortArbiterPkg;

  typedef enum logic [1:0] {
    AGU_NO_EXCEPTION,
    AGU_ADDR_MISALIGN,
    AGU_ACCESS_FAULT,
    AGU_PAGE_FAULT
  } AGU_Exception;

  typedef struct packed {
    logic [31:0]  addr;
    logic         signExtend;
    logic [1:0]   size;
    logic [6:0]   tagDst;
    logic [5:0]   sqN;
    logic         doNotCommit;
    AGU_Exception exception;
    logic         isMMIO;
    logic         external;
    logic         valid;
  } LD_UOp;

  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
  } PW_LD_UOp;

endpackage

module load_port_arbiter
  import LoadPortArbiterPkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     IN_flush,
  input  LD_UOp    IN_aguLd,
  output logic     OUT_aguLdStall,
  input  PW_LD_UOp IN_pwLd,
  output logic     OUT_pwLdStall,
  input  logic     IN_ldUOpStall,
  output LD_UOp    OUT_ldUOp,
  output logic     OUT_pwStarved
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  LD_UOp            oreg;
  logic [CNT_W-1:0] scnt;

  logic  canAccept;
  logic  aguV;
  logic  pwForce;
  logic  grantPW;
  logic  grantAGU;
  LD_UOp aguUop;
  LD_UOp pwUop;

  // Grants are suppressed while reset is held so nothing is accepted then.
  always_comb begin
    canAccept = !oreg.valid || !IN_ldUOpStall;
    aguV      = IN_aguLd.valid && !IN_flush;
    pwForce   = (scnt == LIMIT);
    grantPW   = rst_n && canAccept && IN_pwLd.valid && (pwForce || !aguV);
    grantAGU  = rst_n && canAccept && aguV && !grantPW;
  end

  always_comb begin
    aguUop          = IN_aguLd;
    aguUop.external = 1'b0;
    aguUop.valid    = 1'b1;

    pwUop             = '0;
    pwUop.addr        = IN_pwLd.addr;
    pwUop.size        = 2'd2;
    pwUop.tagDst      = 7'h40;
    pwUop.doNotCommit = 1'b1;
    pwUop.exception   = AGU_NO_EXCEPTION;
    pwUop.external    = 1'b1;
    pwUop.valid       = 1'b1;
  end

  always_comb begin
    OUT_aguLdStall = !rst_n || (IN_aguLd.valid && !IN_flush && !grantAGU);
    OUT_pwLdStall  = !rst_n || (IN_pwLd.valid && !grantPW);
    OUT_ldUOp      = oreg;
    OUT_pwStarved  = (scnt == LIMIT);
  end

  // A held speculative AGU load dies on flush even under downstream stall;
  // a held page-walker load is external and always survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oreg <= '0;
      scnt <= '0;
    end else begin
      if (grantPW) begin
        oreg <= pwUop;
      end else if (grantAGU) begin
        oreg <= aguUop;
      end else if (canAccept || (IN_flush && !oreg.external)) begin
        oreg.valid <= 1'b0;
      end

      if (grantPW || !IN_pwLd.valid) begin
        scnt <= '0;
      end else if (grantAGU && scnt != LIMIT) begin
        scnt <= scnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_port_arbiter.sv
// Randomized scoreboard bench for load_port_arbiter with a rule-level
// reference model of grants, the output register and page-walker starvation.
module tb_load_port_arbiter;
  import LoadPortArbiterPkg::*;

  localparam int STARVE_LIMIT = 8;
  localparam int CNT_W        = 4;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     IN_flush;
  LD_UOp    IN_aguLd;
  logic     OUT_aguLdStall;
  PW_LD_UOp IN_pwLd;
  logic     OUT_pwLdStall;
  logic     IN_ldUOpStall;
  LD_UOp    OUT_ldUOp;
  logic     OUT_pwStarved;

  load_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .IN_flush(IN_flush),
    .IN_aguLd(IN_aguLd),
    .OUT_aguLdStall(OUT_aguLdStall),
    .IN_pwLd(IN_pwLd),
    .OUT_pwLdStall(OUT_pwLdStall),
    .IN_ldUOpStall(IN_ldUOpStall),
    .OUT_ldUOp(OUT_ldUOp),
    .OUT_pwStarved(OUT_pwStarved)
  );

  always #5 clk = ~clk;

  int    testsRun = 0;
  int    testsFailed = 0;
  LD_UOp expQ[$];

  // Reference model state: is a uop held, is it external, and how many times in a row PW has lost.
  bit    mValid = 1'b0;
  bit    mExt = 1'b0;
  int    mLosses = 0;
  bit    lastAguStall = 1'b0;
  bit    lastPwStall = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic LD_UOp randAgu();
    LD_UOp r;
    r.addr        = $urandom;
    r.signExtend  = 1'($urandom_range(0, 1));
    r.size        = 2'($urandom_range(0, 3));
    r.tagDst      = 7'($urandom_range(0, 127));
    r.sqN         = 6'($urandom_range(0, 63));
    r.doNotCommit = 1'($urandom_range(0, 1));
    r.exception   = AGU_Exception'($urandom_range(0, 3));
    r.isMMIO      = 1'($urandom_range(0, 1));
    r.external    = 1'($urandom_range(0, 1));
    r.valid       = 1'b1;
    return r;
  endfunction

  function automatic PW_LD_UOp mkPw(input logic [31:0] addr, input logic v);
    PW_LD_UOp p;
    p.addr  = addr;
    p.valid = v;
    return p;
  endfunction

  // Drives one cycle of inputs, checks combinational outputs against the model
  // just before the edge, then advances the model and queues any granted uop.
  task automatic applyStimulus(input LD_UOp agu, input PW_LD_UOp pw, input logic flush,
                               input logic dsStall, input logic rstn);
    bit    room, aguWants, pwWins, aguWins, expAguStall, expPwStall;
    LD_UOp e;
    IN_aguLd      = agu;
    IN_pwLd       = pw;
    IN_flush      = flush;
    IN_ldUOpStall = dsStall;
    rst_n         = rstn;
    @(negedge clk);
    room     = !mValid || !dsStall;
    aguWants = agu.valid && !flush;
    pwWins   = rstn && room && pw.valid && (mLosses == STARVE_LIMIT || !aguWants);
    aguWins  = rstn && room && aguWants && !pwWins;
    expAguStall = !rstn || (aguWants && !aguWins);
    expPwStall  = !rstn || (pw.valid && !pwWins);

    checkOutput("aguStall", 64'(OUT_aguLdStall), 64'(expAguStall));
    checkOutput("pwStall", 64'(OUT_pwLdStall), 64'(expPwStall));
    checkOutput("outValid", 64'(OUT_ldUOp.valid), 64'(mValid));
    checkOutput("pwStarved", 64'(OUT_pwStarved), 64'(mLosses == STARVE_LIMIT));

    lastAguStall = expAguStall;
    lastPwStall  = expPwStall;

    if (!rstn) begin
      mValid  = 1'b0;
      mExt    = 1'b0;
      mLosses = 0;
    end else begin
      if (pwWins) begin
        e             = '0;
        e.addr        = pw.addr;
        e.size        = 2'd2;
        e.tagDst      = 7'h40;
        e.doNotCommit = 1'b1;
        e.exception   = AGU_NO_EXCEPTION;
        e.external    = 1'b1;
        e.valid       = 1'b1;
        expQ.push_back(e);
        mValid = 1'b1;
        mExt   = 1'b1;
      end else if (aguWins) begin
        e          = agu;
        e.external = 1'b0;
        e.valid    = 1'b1;
        expQ.push_back(e);
        mValid = 1'b1;
        mExt   = 1'b0;
      end else if (room || (flush && !mExt)) begin
        mValid = 1'b0;
      end

      if (pwWins || !pw.valid) mLosses = 0;
      else if (aguWins) mLosses = (mLosses + 1 > STARVE_LIMIT) ? STARVE_LIMIT : mLosses + 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: a uop is newly presented unless last cycle's uop was held by downstream stall.
  initial begin
    bit    prevValid = 1'b0;
    bit    prevStall = 1'b0;
    LD_UOp exp;
    forever begin
      @(negedge clk);
      if (OUT_ldUOp.valid === 1'b1 && !(prevValid && prevStall)) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedUop", 64'(OUT_ldUOp), 64'(0));
        end else begin
          exp = expQ.pop_front();
          checkOutput("uopContents", 64'(OUT_ldUOp), 64'(exp));
        end
      end
      prevValid = (OUT_ldUOp.valid === 1'b1);
      prevStall = IN_ldUOpStall;
    end
  end

  initial begin
    LD_UOp    noAgu, aguCur;
    PW_LD_UOp noPw, pwCur;
    logic     fl, ds, rs;
    noAgu = '0;
    noPw  = mkPw(32'h0, 1'b0);
    rst_n = 1'b0;
    IN_flush = 1'b0;
    IN_aguLd = '0;
    IN_pwLd = noPw;
    IN_ldUOpStall = 1'b0;

    // Reset with both requesters active, then the first grant goes to AGU.
    aguCur = randAgu();
    pwCur  = mkPw($urandom, 1'b1);
    applyStimulus(aguCur, pwCur, 1'b0, 1'b0, 1'b0);
    applyStimulus(aguCur, pwCur, 1'b0, 1'b0, 1'b0);
    applyStimulus(aguCur, pwCur, 1'b0, 1'b0, 1'b1);
    applyStimulus(noAgu, noPw, 1'b0, 1'b0, 1'b1);

    // Page-walker-only request fills the fixed fields.
    applyStimulus(noAgu, mkPw(32'h8000_1000, 1'b1), 1'b0, 1'b0, 1'b1);
    applyStimulus(noAgu, noPw, 1'b0, 1'b0, 1'b1);

    // Continuous contention: eight AGU wins, then one forced PW win, repeatedly.
    aguCur = randAgu();
    pwCur  = mkPw($urandom, 1'b1);
    for (int i = 0; i < 24; i++) begin
      applyStimulus(aguCur, pwCur, 1'b0, 1'b0, 1'b1);
      if (!lastAguStall) aguCur = randAgu();
      if (!lastPwStall) pwCur.addr = $urandom;
    end

    // Downstream backpressure for five cycles, then release with no bubble.
    applyStimulus(noAgu, noPw, 1'b0, 1'b0, 1'b1);
    applyStimulus(aguCur, noPw, 1'b0, 1'b0, 1'b1);
    aguCur = randAgu();
    for (int i = 0; i < 5; i++) applyStimulus(aguCur, pwCur, 1'b0, 1'b1, 1'b1);
    applyStimulus(aguCur, pwCur, 1'b0, 1'b0, 1'b1);
    applyStimulus(noAgu, noPw, 1'b0, 1'b0, 1'b1);

    // Held AGU uop flushed under stall; held PW uop survives flush.
    applyStimulus(randAgu(), noPw, 1'b0, 1'b0, 1'b1);
    applyStimulus(noAgu, noPw, 1'b1, 1'b1, 1'b1);
    applyStimulus(noAgu, noPw, 1'b0, 1'b1, 1'b1);
    applyStimulus(noAgu, mkPw(32'h1234_5678, 1'b1), 1'b0, 1'b0, 1'b1);
    applyStimulus(randAgu(), noPw, 1'b1, 1'b1, 1'b1);
    applyStimulus(noAgu, noPw, 1'b0, 1'b1, 1'b1);
    applyStimulus(noAgu, noPw, 1'b0, 1'b0, 1'b1);

    // AGU request during flush is dropped; flush with both valid grants PW.
    applyStimulus(randAgu(), noPw, 1'b1, 1'b0, 1'b1);
    applyStimulus(noAgu, noPw, 1'b0, 1'b0, 1'b1);
    applyStimulus(randAgu(), mkPw(32'hCAFE_0040, 1'b1), 1'b1, 1'b0, 1'b1);
    applyStimulus(noAgu, noPw, 1'b0, 1'b0, 1'b1);

    // Random traffic with stalls, flushes and occasional mid-run resets.
    aguCur = randAgu();
    aguCur.valid = 1'b0;
    pwCur = noPw;
    for (int i = 0; i < 600; i++) begin
      if (!lastAguStall) begin
        aguCur = randAgu();
        aguCur.valid = ($urandom_range(0, 99) < 70);
      end
      if (!lastPwStall) pwCur = mkPw($urandom, $urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 8);
      ds = ($urandom_range(0, 99) < 30);
      rs = ($urandom_range(0, 99) >= 2);
      applyStimulus(aguCur, pwCur, fl, ds, rs);
    end

    for (int i = 0; i < 3; i++) applyStimulus(noAgu, noPw, 1'b0, 1'b0, 1'b1);
    checkOutput("queueDrained", 64'(expQ.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
